// File: rtl/timer_multi.sv
// Multi-channel down-counting timer on an 8-bit CPU bus: per-channel reload,
// one-shot/auto-reload, shared prescaler, and maskable interrupts ORed onto intr.
module timer_multi #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 2,
   parameter int AW       = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] AD,
   input  logic [7:0]    DI,
   output logic [7:0]    DO,
   input  logic          rw,
   input  logic          cs,
   output logic          intr
);
   localparam int NB = WIDTH / 8;
   localparam logic [AW-1:0] PSC_ADDR = AW'(8 * CHANNELS);

   logic [WIDTH-1:0]    reload_reg  [CHANNELS];
   logic [WIDTH-1:0]    counter_reg [CHANNELS];
   logic [WIDTH-1:0]    reload_next [CHANNELS];
   logic [3:0]          ctrl_reg    [CHANNELS];
   logic [CHANNELS-1:0] run_reg;
   logic [CHANNELS-1:0] pend_reg;
   logic [7:0]          psc_reg;
   logic [7:0]          pcnt_reg;
   logic [23:0]         latch_reg;
   logic                intr_reg;

   logic                wr_en;
   logic                psc_wr;
   logic                ptick;
   logic                latch_rd;
   logic [AW-4:0]       ch_idx;
   logic [CHANNELS-1:0] ch_wr, load, ctrl_wr, w1c, tick, expire, ie;
   logic                ch_hit;
   logic [WIDTH-1:0]    sel_cnt;
   logic [3:0]          sel_ctrl;
   logic                sel_run;
   logic                sel_pend;

   assign wr_en    = cs & ~rw;
   assign psc_wr   = wr_en && (AD == PSC_ADDR);
   assign ptick    = (pcnt_reg == 8'd0);
   assign ch_idx   = AD[AW-1:3];
   assign latch_rd = cs && rw && ch_hit && (AD[2:0] == 3'd0);
   assign intr     = intr_reg;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign ch_wr[gi]   = wr_en && (ch_idx == (AW-3)'(gi));
      assign load[gi]    = ch_wr[gi] && (AD[2:0] == 3'(NB - 1));
      assign ctrl_wr[gi] = ch_wr[gi] && (AD[2:0] == 3'd4);
      assign w1c[gi]     = ch_wr[gi] && (AD[2:0] == 3'd5) && DI[0];
      assign ie[gi]      = ctrl_reg[gi][2];
      assign tick[gi]    = ctrl_reg[gi][0] && (ctrl_reg[gi][3] ? ptick : 1'b1);
      assign expire[gi]  = run_reg[gi] && tick[gi] && (counter_reg[gi] == WIDTH'(1));
   end

   // Reload byte merge and read-side channel select share one loop.
   always_comb begin
      ch_hit   = 1'b0;
      sel_cnt  = '0;
      sel_ctrl = '0;
      sel_run  = 1'b0;
      sel_pend = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         reload_next[c] = reload_reg[c];
         for (int k = 0; k < NB; k++) begin
            if (ch_wr[c] && (AD[2:0] == 3'(k))) reload_next[c][8*k +: 8] = DI;
         end
         if (int'(ch_idx) == c) begin
            ch_hit   = 1'b1;
            sel_cnt  = counter_reg[c];
            sel_ctrl = ctrl_reg[c];
            sel_run  = run_reg[c];
            sel_pend = pend_reg[c];
         end
      end
   end

   always_comb begin
      DO = 8'hFF;
      if (AD == PSC_ADDR) begin
         DO = psc_reg;
      end else if (ch_hit) begin
         case (AD[2:0])
            3'd0:    DO = sel_cnt[7:0];
            3'd1:    DO = latch_reg[7:0];
            3'd2:    DO = latch_reg[15:8];
            3'd3:    DO = latch_reg[23:16];
            3'd4:    DO = {4'b0, sel_ctrl};
            3'd5:    DO = {6'b0, sel_run, sel_pend};
            default: DO = 8'hFF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            reload_reg[c]  <= '0;
            counter_reg[c] <= '0;
            ctrl_reg[c]    <= '0;
         end
         run_reg   <= '0;
         pend_reg  <= '0;
         psc_reg   <= '0;
         pcnt_reg  <= '0;
         latch_reg <= '0;
         intr_reg  <= 1'b0;
      end else begin
         if (psc_wr) begin
            psc_reg  <= DI;
            pcnt_reg <= DI;
         end else if (ptick) begin
            pcnt_reg <= psc_reg;
         end else begin
            pcnt_reg <= pcnt_reg - 8'd1;
         end
         for (int c = 0; c < CHANNELS; c++) begin
            reload_reg[c] <= reload_next[c];
            if (ctrl_wr[c]) ctrl_reg[c] <= DI[3:0];
            // A load overrides whatever the count would have done this edge.
            if (load[c]) begin
               counter_reg[c] <= reload_next[c];
               run_reg[c]     <= |reload_next[c];
            end else if (expire[c]) begin
               counter_reg[c] <= ctrl_reg[c][1] ? reload_reg[c] : '0;
               run_reg[c]     <= ctrl_reg[c][1];
            end else if (run_reg[c] && tick[c] && (counter_reg[c] > WIDTH'(1))) begin
               counter_reg[c] <= counter_reg[c] - WIDTH'(1);
            end
            if (expire[c])   pend_reg[c] <= 1'b1;
            else if (w1c[c]) pend_reg[c] <= 1'b0;
         end
         if (latch_rd) latch_reg <= 24'(sel_cnt >> 8);
         intr_reg <= |(pend_reg & ie);
      end
   end
endmodule

// File: tb/tb_timer_multi.sv
// Scenario bench for timer_multi: expected bytes are queued as stimulus is
// driven and popped when the corresponding bus read or intr sample is taken.
module tb_timer_multi;
   localparam int WIDTH = 16, CHANNELS = 2, AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] AD  = '0;
   logic [7:0]    DI  = '0;
   logic [7:0]    DO;
   logic          rw  = 1'b1;
   logic          cs  = 1'b0;
   logic          intr;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got, exp_v;

   timer_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .AW(AW)) dut (
      .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .intr(intr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      AD = a; DI = d; rw = 1'b0; cs = 1'b1;
      @(posedge clk); #1;
      cs = 1'b0; rw = 1'b1;
      $display("WR   addr=%0d data=%h", a, d);
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [7:0] d);
      AD = a; rw = 1'b1; cs = 1'b0;
      #1 d = DO;
   endtask

   // Chip-selected read: samples DO now and latches upper bytes at the next edge.
   task automatic rd_lat(input logic [AW-1:0] a, output logic [7:0] d);
      AD = a; rw = 1'b1; cs = 1'b1;
      #1 d = DO;
      @(posedge clk); #1;
      cs = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [AW-1:0] addr_tab [7] = '{0, 2, 4, 5, 13, 6, 17};
      logic [7:0]    val_tab  [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(val_tab[i]); rd(addr_tab[i], got); exp_v = exp_q.pop_front(); n_cmp++;
         if (got !== exp_v) begin n_err++; $display("FAIL reset_reg addr=%0d: got %h expected %h", addr_tab[i], got, exp_v); end
         else $display("CHK  reset_reg addr=%0d = %h", addr_tab[i], got);
      end
      exp_q.push_back(8'h00); rd(6'd16, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL reset_psc: got %h expected %h", got, exp_v); end
      else $display("CHK  reset_psc = %h", got);
      exp_q.push_back(8'h00); got = {7'b0, intr}; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL reset_intr: got %h expected %h", got, exp_v); end
      else $display("CHK  reset_intr = %h", got);
   endtask

   task automatic test_oneshot();
      do_reset();
      wr(6'd4, 8'h05); wr(6'd0, 8'h03); wr(6'd1, 8'h00);
      exp_q.push_back(8'h03); rd(6'd0, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL os_load: got %h expected %h", got, exp_v); end
      else $display("CHK  os_load = %h", got);
      idle(2);
      exp_q.push_back(8'h02); rd(6'd5, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL os_stat_run: got %h expected %h", got, exp_v); end
      else $display("CHK  os_stat_run = %h", got);
      idle(1);
      exp_q.push_back(8'h01); rd(6'd5, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL os_stat_exp: got %h expected %h", got, exp_v); end
      else $display("CHK  os_stat_exp = %h", got);
      exp_q.push_back(8'h00); rd(6'd0, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL os_cnt_zero: got %h expected %h", got, exp_v); end
      else $display("CHK  os_cnt_zero = %h", got);
      exp_q.push_back(8'h00); got = {7'b0, intr}; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL os_intr_lag: got %h expected %h", got, exp_v); end
      else $display("CHK  os_intr_lag = %h", got);
      idle(1);
      exp_q.push_back(8'h01); got = {7'b0, intr}; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL os_intr_rise: got %h expected %h", got, exp_v); end
      else $display("CHK  os_intr_rise = %h", got);
      wr(6'd5, 8'h01);
      exp_q.push_back(8'h00); rd(6'd5, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL os_w1c: got %h expected %h", got, exp_v); end
      else $display("CHK  os_w1c = %h", got);
      idle(1);
      exp_q.push_back(8'h00); got = {7'b0, intr}; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL os_intr_fall: got %h expected %h", got, exp_v); end
      else $display("CHK  os_intr_fall = %h", got);
   endtask

   task automatic test_auto();
      do_reset();
      wr(6'd12, 8'h07); wr(6'd8, 8'h02); wr(6'd9, 8'h00);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back((i % 2 == 0) ? 8'h02 : 8'h01);
         rd(6'd8, got); exp_v = exp_q.pop_front(); n_cmp++;
         if (got !== exp_v) begin n_err++; $display("FAIL auto_cnt[%0d]: got %h expected %h", i, got, exp_v); end
         else $display("CHK  auto_cnt[%0d] = %h", i, got);
         idle(1);
      end
      idle(6);
      exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h01);
      rd(6'd8, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL auto_cnt10: got %h expected %h", got, exp_v); end
      else $display("CHK  auto_cnt10 = %h", got);
      rd(6'd13, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL auto_stat10: got %h expected %h", got, exp_v); end
      else $display("CHK  auto_stat10 = %h", got);
      got = {7'b0, intr}; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL auto_intr: got %h expected %h", got, exp_v); end
      else $display("CHK  auto_intr = %h", got);
   endtask

   task automatic test_prescaler();
      do_reset();
      wr(6'd0, 8'h02); wr(6'd4, 8'h0D); wr(6'd16, 8'h03);
      exp_q.push_back(8'h03); rd(6'd16, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL psc_rb: got %h expected %h", got, exp_v); end
      else $display("CHK  psc_rb = %h", got);
      idle(3);
      wr(6'd1, 8'h00);
      for (int i = 1; i <= 8; i++) begin
         idle(1);
         exp_q.push_back((i < 4) ? 8'h02 : (i < 8) ? 8'h01 : 8'h00);
         exp_q.push_back((i < 8) ? 8'h02 : 8'h01);
         rd(6'd0, got); exp_v = exp_q.pop_front(); n_cmp++;
         if (got !== exp_v) begin n_err++; $display("FAIL psc_cnt[%0d]: got %h expected %h", i, got, exp_v); end
         else $display("CHK  psc_cnt[%0d] = %h", i, got);
         rd(6'd5, got); exp_v = exp_q.pop_front(); n_cmp++;
         if (got !== exp_v) begin n_err++; $display("FAIL psc_stat[%0d]: got %h expected %h", i, got, exp_v); end
         else $display("CHK  psc_stat[%0d] = %h", i, got);
      end
   endtask

   task automatic test_freeze();
      do_reset();
      wr(6'd4, 8'h01); wr(6'd0, 8'h34); wr(6'd1, 8'h12);
      idle(2);
      wr(6'd4, 8'h00);
      idle(5);
      exp_q.push_back(8'h31); exp_q.push_back(8'h02); exp_q.push_back(8'h12);
      rd(6'd0, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL frz_lo: got %h expected %h", got, exp_v); end
      else $display("CHK  frz_lo = %h", got);
      rd(6'd5, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL frz_stat: got %h expected %h", got, exp_v); end
      else $display("CHK  frz_stat = %h", got);
      rd_lat(6'd0, got);
      rd(6'd1, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL frz_hi: got %h expected %h", got, exp_v); end
      else $display("CHK  frz_hi = %h", got);
      wr(6'd4, 8'h01);
      idle(1);
      exp_q.push_back(8'h30); rd(6'd0, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL frz_resume: got %h expected %h", got, exp_v); end
      else $display("CHK  frz_resume = %h", got);
      wr(6'd0, 8'h00); wr(6'd1, 8'h00);
      idle(3);
      exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      rd(6'd5, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL zero_stat: got %h expected %h", got, exp_v); end
      else $display("CHK  zero_stat = %h", got);
      rd(6'd0, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL zero_cnt: got %h expected %h", got, exp_v); end
      else $display("CHK  zero_cnt = %h", got);
   endtask

   task automatic test_collide();
      do_reset();
      wr(6'd4, 8'h07); wr(6'd0, 8'h02); wr(6'd1, 8'h00);
      idle(3);
      wr(6'd5, 8'h01);
      exp_q.push_back(8'h03); rd(6'd5, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL col_w1c_stat: got %h expected %h", got, exp_v); end
      else $display("CHK  col_w1c_stat = %h", got);
      exp_q.push_back(8'h01); got = {7'b0, intr}; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL col_w1c_intr: got %h expected %h", got, exp_v); end
      else $display("CHK  col_w1c_intr = %h", got);
      wr(6'd5, 8'h01);
      exp_q.push_back(8'h02); rd(6'd5, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL col_clr: got %h expected %h", got, exp_v); end
      else $display("CHK  col_clr = %h", got);
      idle(1);
      wr(6'd5, 8'h01);
      wr(6'd1, 8'h01);
      exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'h01);
      rd(6'd0, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL col_load_lo: got %h expected %h", got, exp_v); end
      else $display("CHK  col_load_lo = %h", got);
      rd(6'd5, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL col_load_stat: got %h expected %h", got, exp_v); end
      else $display("CHK  col_load_stat = %h", got);
      rd_lat(6'd0, got);
      rd(6'd1, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL col_load_hi: got %h expected %h", got, exp_v); end
      else $display("CHK  col_load_hi = %h", got);
   endtask

   task automatic test_latch_reset();
      do_reset();
      wr(6'd4, 8'h01); wr(6'd0, 8'h02); wr(6'd1, 8'h01);
      idle(2);
      exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'hFD);
      rd_lat(6'd0, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL lat_lo: got %h expected %h", got, exp_v); end
      else $display("CHK  lat_lo = %h", got);
      idle(2);
      rd(6'd1, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL lat_hi: got %h expected %h", got, exp_v); end
      else $display("CHK  lat_hi = %h", got);
      rd(6'd0, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL lat_live: got %h expected %h", got, exp_v); end
      else $display("CHK  lat_live = %h", got);
      wr(6'd12, 8'h07); wr(6'd8, 8'h02); wr(6'd9, 8'h00);
      idle(3);
      exp_q.push_back(8'h01); got = {7'b0, intr}; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL rst_pre_intr: got %h expected %h", got, exp_v); end
      else $display("CHK  rst_pre_intr = %h", got);
      do_reset();
      exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      rd(6'd5, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL rst_stat0: got %h expected %h", got, exp_v); end
      else $display("CHK  rst_stat0 = %h", got);
      rd(6'd13, got); exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL rst_stat1: got %h expected %h", got, exp_v); end
      else $display("CHK  rst_stat1 = %h", got);
      got = {7'b0, intr}; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL rst_intr: got %h expected %h", got, exp_v); end
      else $display("CHK  rst_intr = %h", got);
      idle(2);
      exp_q.push_back(8'h00); got = {7'b0, intr}; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin n_err++; $display("FAIL rst_no_pulse: got %h expected %h", got, exp_v); end
      else $display("CHK  rst_no_pulse = %h", got);
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_auto();
      test_prescaler();
      test_freeze();
      test_collide();
      test_latch_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
